multicycle_control_unit: RTL

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/mips_mc_pkg.sv | 65 ++++++
 rtl/mc_out_decode.sv | 100 ++++++++++
 rtl/multicycle_control_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes, opcodes,
// ALU operation and datapath mux select codes, plus the decoded control bundle.
package mips_mc_pkg;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_IEXEC  = 4'd9;
    localparam logic [3:0] S_IWB    = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_TRAP   = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal_op;
    } ctrl_t;

    // Opcodes that only exist when the extended instruction set is enabled.
    function automatic logic is_ext_op(input logic [5:0] op);
        return (op == OP_BNE) || (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational state-to-control decode. Everything not named for a state is 0;
// i_opcode is the copy latched in DECODE, never the live instruction bus.
module mc_out_decode
    import mips_mc_pkg::*;
(
    input  logic [3:0] i_state,
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_mem_done,
    output logic       o_iord,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_pc_en,
    output logic [1:0] o_pc_src,
    output logic [2:0] o_alu_op,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic       o_reg_write,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_illegal_op
);

    ctrl_t w_ctrl;

    always_comb begin
        w_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.ir_write  = i_mem_done;
                w_ctrl.pc_en     = i_mem_done;
            end
            S_DECODE: w_ctrl.alu_src_b = SRCB_IMM_SH2;
            S_MEMADR: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_op    = ALU_SUB;
                w_ctrl.pc_src    = PC_ALUOUT;
                w_ctrl.pc_en     = (i_opcode == OP_BNE) ? ~i_zero : i_zero;
            end
            S_IEXEC: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
                case (i_opcode)
                    OP_ANDI: w_ctrl.alu_op = ALU_AND;
                    OP_ORI:  w_ctrl.alu_op = ALU_OR;
                    default: w_ctrl.alu_op = ALU_ADD;
                endcase
            end
            S_IWB:  w_ctrl.reg_write = 1'b1;
            S_JUMP: begin
                w_ctrl.pc_en  = 1'b1;
                w_ctrl.pc_src = PC_JUMP;
            end
            S_TRAP: w_ctrl.illegal_op = 1'b1;
            default: w_ctrl = '0;
        endcase
    end

    assign o_iord       = w_ctrl.iord;
    assign o_mem_read   = w_ctrl.mem_read;
    assign o_mem_write  = w_ctrl.mem_write;
    assign o_ir_write   = w_ctrl.ir_write;
    assign o_pc_en      = w_ctrl.pc_en;
    assign o_pc_src     = w_ctrl.pc_src;
    assign o_alu_op     = w_ctrl.alu_op;
    assign o_alu_src_a  = w_ctrl.alu_src_a;
    assign o_alu_src_b  = w_ctrl.alu_src_b;
    assign o_reg_write  = w_ctrl.reg_write;
    assign o_reg_dst    = w_ctrl.reg_dst;
    assign o_mem_to_reg = w_ctrl.mem_to_reg;
    assign o_illegal_op = w_ctrl.illegal_op;

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: state register, next-state logic and the
// retired-instruction counter. Control outputs come from mc_out_decode.
module multicycle_control_unit
    import mips_mc_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int EXT_OPS       = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             pc_en,
    output logic [1:0]       PCSrc,
    output logic [2:0]       ALUOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state_o
);

    logic [3:0]       r_state;
    logic [3:0]       w_next_state;
    logic [5:0]       r_opcode;
    logic [CNT_W-1:0] r_instr_count;
    logic             w_mem_done;
    logic             w_ext;
    logic             w_retire;
    logic             w_mem_write;
    logic             w_ir_write;
    logic             w_pc_en;
    logic             w_reg_write;

    // Memory handshake: FETCH/MEMRD/MEMWR hold their request (and state) until
    // mem_ready is high at a rising edge; that edge completes the access.
    // Without the handshake every access completes in its first cycle.
    assign w_mem_done = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign w_ext      = (EXT_OPS != 0);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:  if (w_mem_done) w_next_state = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:      w_next_state = S_EXEC;
                    OP_LW, OP_SW:  w_next_state = S_MEMADR;
                    OP_BEQ:        w_next_state = S_BRANCH;
                    OP_BNE:        w_next_state = S_BRANCH;
                    OP_ADDI:       w_next_state = S_IEXEC;
                    OP_ANDI,
                    OP_ORI:        w_next_state = S_IEXEC;
                    OP_J:          w_next_state = S_JUMP;
                    default:       w_next_state = S_TRAP;
                endcase
                if (is_ext_op(Opcode) && !w_ext) w_next_state = S_TRAP;
            end
            S_MEMADR: w_next_state = (r_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (w_mem_done) w_next_state = S_MEMWB;
            S_MEMWB:  w_next_state = S_FETCH;
            S_MEMWR:  if (w_mem_done) w_next_state = S_FETCH;
            S_EXEC:   w_next_state = S_ALUWB;
            S_ALUWB:  w_next_state = S_FETCH;
            S_BRANCH: w_next_state = S_FETCH;
            S_IEXEC:  w_next_state = S_IWB;
            S_IWB:    w_next_state = S_FETCH;
            S_JUMP:   w_next_state = S_FETCH;
            S_TRAP:   w_next_state = S_FETCH;
            default:  w_next_state = S_FETCH;
        endcase
    end

    // A trap returns to FETCH without retiring anything.
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP: w_retire = 1'b1;
            S_MEMWR:                                    w_retire = w_mem_done;
            default:                                    w_retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_FETCH;
            r_opcode      <= '0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DECODE) r_opcode <= Opcode;
            if (w_retire) r_instr_count <= r_instr_count + CNT_W'(1);
        end
    end

    mc_out_decode u_out_decode (
        .i_state      (r_state),
        .i_opcode     (r_opcode),
        .i_zero       (Zero),
        .i_mem_done   (w_mem_done),
        .o_iord       (IorD),
        .o_mem_read   (MemRead),
        .o_mem_write  (w_mem_write),
        .o_ir_write   (w_ir_write),
        .o_pc_en      (w_pc_en),
        .o_pc_src     (PCSrc),
        .o_alu_op     (ALUOp),
        .o_alu_src_a  (ALUSrcA),
        .o_alu_src_b  (ALUSrcB),
        .o_reg_write  (w_reg_write),
        .o_reg_dst    (RegDst),
        .o_mem_to_reg (MemtoReg),
        .o_illegal_op (illegal_op)
    );

    // FETCH with a ready memory would otherwise load IR/PC while reset is held.
    assign MemWrite    = w_mem_write & reset;
    assign IRWrite     = w_ir_write  & reset;
    assign pc_en       = w_pc_en     & reset;
    assign RegWrite    = w_reg_write & reset;
    assign instr_count = r_instr_count;
    assign state_o     = r_state;

endmodule
